// File: rtl/hidden_cpu_core.sv
// hidden_cpu_core: streamed single-issue accumulator core with register file, carry flag, PC and scratch RAM.
// Optional `HIDDENCPU_CARRY_BANK_EN` doubles RAM depth and uses the carry flag as the RAM bank bit.
module hidden_cpu_core #(
  parameter int DATA_W     = 8,
  parameter int REG_COUNT  = 4,
  parameter int RAM_ADDR_W = 3,
  localparam int RSEL_W    = $clog2(REG_COUNT),
  localparam int INSTR_W   = 2 + 2 * RSEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [DATA_W-1:0]  dout,
  output logic               carry
);

`ifdef HIDDENCPU_CARRY_BANK_EN
  localparam int MEM_AW = RAM_ADDR_W + 1;
`else
  localparam int MEM_AW = RAM_ADDR_W;
`endif
  localparam int MEM_DEPTH = 2 ** MEM_AW;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_SYS  = 2'b11;

  localparam logic [RSEL_W-1:0] SYS_STORE = RSEL_W'(0);
  localparam logic [RSEL_W-1:0] SYS_LOAD  = RSEL_W'(1);
  localparam logic [RSEL_W-1:0] SYS_BCS   = RSEL_W'(2);
  localparam logic [RSEL_W-1:0] SYS_TOG   = RSEL_W'(3);

  typedef enum logic {ST_EXEC = 1'b0, ST_LOAD_WB = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_regs [REG_COUNT];
  logic [DATA_W-1:0]   r_pc;
  logic                r_carry;
  logic                r_sel;
  logic [RSEL_W-1:0]   r_ld_rd;
  logic [MEM_AW-1:0]   r_ld_addr;
  logic [DATA_W-1:0]   r_ram [MEM_DEPTH];

  logic [1:0]          w_op;
  logic [RSEL_W-1:0]   w_rd;
  logic [RSEL_W-1:0]   w_rs;
  logic [DATA_W-1:0]   w_rd_val;
  logic [DATA_W-1:0]   w_rs_val;
  logic [DATA_W:0]     w_sum;
  logic [RAM_ADDR_W-1:0] w_ptr;
  logic [MEM_AW-1:0]   w_addr;
  logic                w_accept;
  logic                w_is_load;

  logic                w_reg_we;
  logic [RSEL_W-1:0]   w_reg_wa;
  logic [DATA_W-1:0]   w_reg_wd;
  logic                w_carry_nxt;
  logic [DATA_W-1:0]   w_pc_nxt;
  logic                w_sel_nxt;
  logic                w_ram_we;

  assign w_op     = instr[INSTR_W-1 -: 2];
  assign w_rd     = instr[2*RSEL_W-1 -: RSEL_W];
  assign w_rs     = instr[RSEL_W-1:0];
  assign w_rd_val = r_regs[w_rd];
  assign w_rs_val = r_regs[w_rs];
  assign w_sum    = {1'b0, w_rd_val} + {1'b0, w_rs_val};
  assign w_ptr    = r_regs[REG_COUNT-2][RAM_ADDR_W-1:0];

`ifdef HIDDENCPU_CARRY_BANK_EN
  // Bank bit is the flag value at acceptance, before this instruction's own update.
  assign w_addr = {r_carry, w_ptr};
`else
  assign w_addr = w_ptr;
`endif

  assign w_accept  = instr_valid & instr_ready;
  assign w_is_load = w_accept & (w_op == OP_SYS) & (w_rs == SYS_LOAD);

  assign dout  = r_sel ? r_pc : r_regs[REG_COUNT-1];
  assign carry = r_carry;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EXEC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EXEC: begin
        if (w_is_load) begin
          w_state_nxt = ST_LOAD_WB;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_LOAD_WB: w_state_nxt = ST_EXEC;
      default:    w_state_nxt = ST_EXEC;
    endcase
  end

  // FSM outputs
  always_comb begin
    instr_ready = 1'b0;
    case (r_state)
      ST_EXEC:    instr_ready = 1'b1;
      ST_LOAD_WB: instr_ready = 1'b0;
      default:    instr_ready = 1'b0;
    endcase
  end

  // Instruction execute: next values for register file, flag, PC, sel and RAM write
  always_comb begin
    w_reg_we    = 1'b0;
    w_reg_wa    = w_rd;
    w_reg_wd    = w_rd_val;
    w_carry_nxt = r_carry;
    w_pc_nxt    = r_pc;
    w_sel_nxt   = r_sel;
    w_ram_we    = 1'b0;
    if (r_state == ST_LOAD_WB) begin
      w_reg_we = 1'b1;
      w_reg_wa = r_ld_rd;
      w_reg_wd = r_ram[r_ld_addr];
    end else if (w_accept) begin
      w_pc_nxt = r_pc + DATA_W'(1);
      case (w_op)
        OP_ADD: begin
          w_reg_we    = 1'b1;
          w_reg_wd    = w_sum[DATA_W-1:0];
          w_carry_nxt = w_sum[DATA_W];
        end
        OP_SUB: begin
          w_reg_we    = 1'b1;
          w_reg_wd    = w_rd_val - w_rs_val;
          w_carry_nxt = (w_rd_val < w_rs_val);
        end
        OP_NAND: begin
          w_reg_we = 1'b1;
          w_reg_wd = ~(w_rd_val & w_rs_val);
        end
        OP_SYS: begin
          case (w_rs)
            SYS_STORE: w_ram_we = ~rst;
            SYS_LOAD:  w_ram_we = 1'b0;
            SYS_BCS: begin
              if (r_carry) begin
                w_pc_nxt = r_pc + w_rd_val;
              end else begin
                w_pc_nxt = r_pc + DATA_W'(1);
              end
            end
            SYS_TOG:   w_sel_nxt = ~r_sel;
            default:   w_ram_we  = 1'b0;
          endcase
        end
        default: w_reg_we = 1'b0;
      endcase
    end else begin
      w_pc_nxt = r_pc;
    end
  end

  // Architectural state and pending-load bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= DATA_W'(i);
      end
      r_pc      <= {DATA_W{1'b0}};
      r_carry   <= 1'b0;
      r_sel     <= 1'b0;
      r_ld_rd   <= {RSEL_W{1'b0}};
      r_ld_addr <= {MEM_AW{1'b0}};
    end else begin
      if (w_reg_we) begin
        r_regs[w_reg_wa] <= w_reg_wd;
      end
      r_pc    <= w_pc_nxt;
      r_carry <= w_carry_nxt;
      r_sel   <= w_sel_nxt;
      if (w_is_load) begin
        r_ld_rd   <= w_rd;
        r_ld_addr <= w_addr;
      end
    end
  end

  // Scratch RAM, deliberately not reset
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[w_addr] <= w_rd_val;
    end
  end

endmodule

// File: tb/tb_hidden_cpu_core.sv
// Bench for hidden_cpu_core: hand-derived vector table for the directed scenarios, then a
// reference-model-driven random stream; expected outputs queue up at drive time and are popped after each edge.
module tb_hidden_cpu_core;

`ifdef HIDDENCPU_CARRY_BANK_EN
  localparam bit BANK_EN = 1'b1;
`else
  localparam bit BANK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] dout;
  logic       carry;

  hidden_cpu_core dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .dout(dout), .carry(carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    bit         valid;
    logic [5:0] instr;
    logic [7:0] dout;
    bit         c;
    bit         rdy;
  } vec_t;

  typedef struct {
    logic [7:0] dout;
    logic       c;
    logic       rdy;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model state
  logic [7:0] m_r [4];
  logic [7:0] m_pc;
  logic       m_c, m_sel, m_st;
  logic [1:0] m_ld_rd;
  logic [3:0] m_ld_addr;
  logic [7:0] m_ram [16];
  bit         m_ok  [16];

  task automatic add_vec(input bit r, input bit v, input logic [5:0] ins,
                         input logic [7:0] d, input bit c, input bit rdy);
    vec_t t;
    t.rst = r; t.valid = v; t.instr = ins; t.dout = d; t.c = c; t.rdy = rdy;
    vecs.push_back(t);
  endtask

  task automatic check_val(input string name, input int step, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, got, exp);
    end
  endtask

  task automatic apply(input bit r, input bit v, input logic [5:0] ins, input exp_t e, input int step);
    exp_t g;
    @(negedge clk);
    rst = r; instr_valid = v; instr = ins;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard step %0d: got empty queue expected one entry", step);
    end else begin
      g = sb.pop_front();
      check_val("dout", step, dout, g.dout);
      check_val("carry", step, {7'd0, carry}, {7'd0, g.c});
      check_val("ready", step, {7'd0, instr_ready}, {7'd0, g.rdy});
    end
  endtask

  function automatic logic [3:0] model_addr();
    return BANK_EN ? {m_c, m_r[2][2:0]} : {1'b0, m_r[2][2:0]};
  endfunction

  task automatic model_step(input bit r, input bit v, input logic [5:0] ins);
    logic [1:0] op, rd, rs;
    logic [7:0] a, b;
    logic [8:0] s;
    logic [3:0] ad;
    op = ins[5:4]; rd = ins[3:2]; rs = ins[1:0];
    a = m_r[rd]; b = m_r[rs]; ad = model_addr();
    if (r) begin
      for (int i = 0; i < 4; i++) m_r[i] = 8'(i);
      m_pc = 8'd0; m_c = 1'b0; m_sel = 1'b0; m_st = 1'b0;
    end else if (m_st) begin
      m_r[m_ld_rd] = m_ram[m_ld_addr];
      m_st = 1'b0;
    end else if (v) begin
      m_pc = m_pc + 8'd1;
      case (op)
        2'd0: begin s = {1'b0, a} + {1'b0, b}; m_r[rd] = s[7:0]; m_c = s[8]; end
        2'd1: begin m_r[rd] = a - b; m_c = (a < b); end
        2'd2: m_r[rd] = ~(a & b);
        default: begin
          case (rs)
            2'd0: begin m_ram[ad] = a; m_ok[ad] = 1'b1; end
            2'd1: begin m_ld_rd = rd; m_ld_addr = ad; m_st = 1'b1; end
            2'd2: if (m_c) m_pc = m_pc - 8'd1 + a;
            default: m_sel = ~m_sel;
          endcase
        end
      endcase
    end
  endtask

  initial begin
    logic [7:0] ld1;
    exp_t       e;
    bit         rv, vv;
    logic [5:0] iv;
    ld1 = BANK_EN ? 8'h01 : 8'h03;
    rst = 1'b1; instr_valid = 1'b0; instr = 6'd0;

    // reset, ADD/SUB, branch, toggle, stall, NAND, wrapping backward branch
    add_vec(1, 0, 6'b000000, 8'h03, 0, 1);
    add_vec(0, 1, 6'b000111, 8'h03, 0, 1);
    add_vec(0, 1, 6'b010001, 8'h03, 1, 1);
    add_vec(0, 1, 6'b111110, 8'h03, 1, 1);
    add_vec(0, 1, 6'b110011, 8'h06, 1, 1);
    add_vec(0, 1, 6'b110011, 8'h03, 1, 1);
    for (int i = 0; i < 5; i++) add_vec(0, 0, 6'b110011, 8'h03, 1, 1);
    add_vec(0, 1, 6'b110011, 8'h08, 1, 1);
    add_vec(0, 1, 6'b110011, 8'h03, 1, 1);
    add_vec(0, 1, 6'b101111, 8'hFC, 1, 1);
    add_vec(0, 1, 6'b001111, 8'hF8, 1, 1);
    add_vec(0, 1, 6'b111110, 8'hF8, 1, 1);
    add_vec(0, 1, 6'b110011, 8'h04, 1, 1);
    add_vec(0, 1, 6'b110011, 8'hF8, 1, 1);
    // store then load; valid held high during the writeback cycle
    add_vec(1, 0, 6'b000000, 8'h03, 0, 1);
    add_vec(0, 1, 6'b110100, 8'h03, 0, 1);
    add_vec(0, 1, 6'b111101, 8'h03, 0, 0);
    add_vec(0, 1, 6'b110011, 8'h01, 0, 1);
    add_vec(0, 1, 6'b110011, 8'h03, 0, 1);
    add_vec(0, 1, 6'b110011, 8'h01, 0, 1);
    // reset during the writeback cycle
    add_vec(0, 1, 6'b111101, 8'h01, 0, 0);
    add_vec(1, 1, 6'b110011, 8'h03, 0, 1);
    add_vec(0, 1, 6'b110011, 8'h01, 0, 1);
    add_vec(0, 1, 6'b110011, 8'h03, 0, 1);
    // carry as bank bit
    add_vec(1, 0, 6'b000000, 8'h03, 0, 1);
    add_vec(0, 1, 6'b010001, 8'h03, 1, 1);
    add_vec(0, 1, 6'b110100, 8'h03, 1, 1);
    add_vec(0, 1, 6'b000101, 8'h03, 0, 1);
    add_vec(0, 1, 6'b111100, 8'h03, 0, 1);
    add_vec(0, 1, 6'b010111, 8'h03, 1, 1);
    add_vec(0, 1, 6'b111101, 8'h03, 1, 0);
    add_vec(0, 0, 6'b000000, ld1,   1, 1);
    add_vec(0, 1, 6'b010000, ld1,   0, 1);
    add_vec(0, 1, 6'b111101, ld1,   0, 0);
    add_vec(0, 0, 6'b000000, 8'h03, 0, 1);
    add_vec(0, 1, 6'b111110, 8'h03, 0, 1);
    add_vec(0, 1, 6'b110011, 8'h0A, 0, 1);
    add_vec(0, 1, 6'b110011, 8'h03, 0, 1);

    foreach (vecs[k]) begin
      e.dout = vecs[k].dout; e.c = vecs[k].c; e.rdy = vecs[k].rdy;
      apply(vecs[k].rst, vecs[k].valid, vecs[k].instr, e, k);
    end

    // random stream against the reference model; loads only target written RAM words
    for (int k = 0; k < 1500; k++) begin
      rv = (k == 0) || ($urandom_range(0, 399) == 0);
      vv = ($urandom_range(0, 3) != 0);
      iv = 6'($urandom);
      if (!rv && !m_st && vv && iv[5:4] == 2'b11 && iv[1:0] == 2'b01 && !m_ok[model_addr()])
        iv[1:0] = 2'b00;
      model_step(rv, vv, iv);
      e.dout = m_sel ? m_pc : m_r[3];
      e.c    = m_c;
      e.rdy  = ~m_st;
      apply(rv, vv, iv, e, 1000 + k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hidden_cpu_core.md
# hidden_cpu_core

Parametrised successor to the TT03 hidden CPU datapath. Single-issue accumulator-style core executing one streamed instruction per accepted cycle on a register file, flag, PC and internal scratch RAM. Generalised in data width, register count and RAM depth; adds a valid/ready instruction handshake and a two-cycle registered LOAD. Sits behind the tile wrapper, which maps the pads to `clk`, `rst`, `instr` and `dout`.

## Interface
- `DATA_W`, 8: width of registers, RAM words, PC and `dout`.
- `REG_COUNT`, 4: number of registers. Must be a power of 2 and at least 4. `RSEL_W = clog2(REG_COUNT)`.
- `RAM_ADDR_W`, 3: RAM pointer width. Base depth is `2**RAM_ADDR_W`.
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `instr`, input, `2+2*RSEL_W`: instruction. Fields are `op=[MSB:MSB-1]`, `rd` (next `RSEL_W` bits) and `rs` (low `RSEL_W` bits).
- `instr_valid`, input, 1: `instr` is presented this cycle.
- `instr_ready`, output, 1: core accepts an instruction this cycle. Combinational from state; high in EXEC.
- `dout`, output, `DATA_W`: `pc` when `sel` is 1, else `r[REG_COUNT-1]`.
- `carry`, output, 1: current flag value.

## Operation
- **Accept:** an instruction is accepted when `instr_valid && instr_ready`. With no accept, no architectural state changes. `pc` is not incremented.
- **Default PC update on accept:** `pc <= pc+1`, modulo `2**DATA_W`.
- **op 00 ADD:** `r[rd] <= r[rd]+r[rs]`; `carry <=` carry-out.
- **op 01 SUB:** `r[rd] <= r[rd]-r[rs]` (mod); `carry <= (r[rd] < r[rs])` unsigned.
- **op 10 NAND:** `r[rd] <= ~(r[rd]&r[rs])`; `carry` unchanged.
- **op 11 SYS:** `rs` selects the sub-op.
  - `ptr = r[REG_COUNT-2][RAM_ADDR_W-1:0]`.
  - 0 STORE: `ram[addr] <= r[rd]`.
  - 1 LOAD: two cycles; see state machine.
  - 2 BCS: if `carry`, `pc <= pc + r[rd]` (mod), else `pc+1`. `carry` unchanged.
  - 3 TOG: `sel <= ~sel`.
  - 4 and above (REG_COUNT ≥ 8 only): NOP, `pc+1`.
- **Operand rules:** `rd==rs` is legal; operands are read before writeback.
- **State machine:**
  - EXEC: `instr_ready=1`. An accepted LOAD registers `addr` and `rd` and moves to LOAD_WB.
  - LOAD_WB: `instr_ready=0`. On the next edge `r[rd] <= ram[addr_q]`, then return to EXEC. `instr_valid` is ignored in LOAD_WB.
- **Reset values:**
  - `pc=0`, `carry=0`, `sel=0`, state EXEC.
  - `r[i] = i` truncated to `DATA_W`.
  - Resulting outputs: `dout = REG_COUNT-1`, `instr_ready=1`, `carry=0`.
  - RAM is not reset; contents are undefined until written.

## Timing
- Results of ADD, SUB, NAND, STORE, BCS and TOG are visible the cycle after the accepting edge.
- LOAD accepted at edge N: `pc` updates at N, `r[rd]` updates at N+1, `instr_ready` is low between N and N+1.
- Back-to-back accepts are allowed every cycle in EXEC. A STORE followed immediately by a LOAD of the same address returns the new data.
- `rst` takes priority over everything. Reset in LOAD_WB aborts the writeback: target register takes its reset value and state returns to EXEC.
- `dout` is combinational from `sel`, `pc` and `r[REG_COUNT-1]`. It changes in the same cycle as those registers.
- Wrap-around: `pc` of `2**DATA_W-1` plus 1 gives 0. Branch offsets wrap the same way (a backward branch is an offset ≥ `2**(DATA_W-1)`).

## Configuration
- Macro: `HIDDENCPU_CARRY_BANK_EN`.
- **Defined:** RAM depth is `2**(RAM_ADDR_W+1)` and `addr = {carry, ptr}`. The flag acts as a bank bit, matching the TT03 core behaviour. The bank is sampled at acceptance.
- **Undefined:** depth is `2**RAM_ADDR_W` and `addr = ptr`. `carry` does not affect memory.

## Test plan
All scenarios use defaults, `instr` 6 bits as `[5:4]` op, `[3:2]` rd, `[1:0]` rs.
- **Reset and SUB:** reset, then accept `000111` (ADD r1,r3) → `r1=4`, `carry=0`, `pc=1`, `dout=3`. Then `010001` (SUB r0,r1) → `r0=0xFC`, `carry=1`, `pc=2`.
- **Branch and toggle:** `carry=1`, `pc=2`. Accept `111110` (BCS r3) → `pc=5`. Accept `110011` (TOG) → `dout=6` (pc). Accept `110011` again → `dout=r3=3`.
- **Store/load:** after reset, STORE `110100` (r1 to ram[2]), then LOAD `111101` (r3 from ram[2]). Expect `instr_ready=0` for exactly one cycle, `r3=1`, `pc=2`. `instr_valid` held high during LOAD_WB is not consumed.
- **Stall:** `instr_valid=0` for 5 cycles → `pc`, all registers, `carry` and `sel` unchanged.
- **Reset mid-LOAD:** assert `rst` in the LOAD_WB cycle → `r3=3`, `pc=0`, `instr_ready=1` the next cycle.
- **Carry bank (macro defined):**
  - With `carry=1`: store `0x55` at `ptr=2`, landing at address 10.
  - With `carry=0`: store `0xAA` at `ptr=2`.
  - Load with `carry=1` → `0x55`; load with `carry=0` → `0xAA`.
  - Macro undefined: both loads return the last value stored.
